// File: rtl/csela_add_sched.sv
`default_nettype none
// ============================================================================
// Module   : csela_add_sched
// Summary  : Round-robin scheduler that shares one external combinational
//            carry-select adder among NREQ requesters. Each requester has a
//            valid/ready request channel and a valid/ready response channel.
//            The scheduler holds the operands for SETTLE_CYC cycles, then
//            registers sum/cout and returns them to the granted requester.
// Option   : CSELA_SCHED_SAT_EN - when defined, a carry-out saturates the
//            returned sum to all ones (unsigned saturation).
// Revision : 1.0 - initial release
// ============================================================================
module csela_add_sched #(
  parameter int W          = 64,
  parameter int NREQ       = 4,
  parameter int SETTLE_CYC = 2,
  localparam int GW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  output logic [NREQ-1:0]     resp_valid,
  input  logic [NREQ-1:0]     resp_ready,
  output logic [W-1:0]        resp_sum,
  output logic                resp_cout,
  output logic [W-1:0]        add_a,
  output logic [W-1:0]        add_b,
  input  logic [W-1:0]        add_sum,
  input  logic                add_cout,
  output logic                busy,
  output logic [GW-1:0]       grant_id
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC);

  state_t          state;
  logic [GW-1:0]   ptr;
  logic [3:0]      cnt;

  logic            sel_found;
  logic [GW-1:0]   sel_idx;
  logic [GW:0]     cand;
  logic [GW-1:0]   ptr_next;

  // Round-robin search: first requester with req_valid, starting at ptr
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (GW+1)'(k);
      if (cand >= (GW+1)'(NREQ)) begin
        cand = cand - (GW+1)'(NREQ);
      end
      if (!sel_found && req_valid[cand[GW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[GW-1:0];
      end
    end
  end

  // Accept is offered only in IDLE and never while reset is held
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == S_IDLE) && sel_found) begin
      req_ready = NREQ'(1) << sel_idx;
    end
  end

  // Pointer moves to the requester after the one just served, wrapping
  always_comb begin
    ptr_next = grant_id + GW'(1);
    if (grant_id == GW'(NREQ - 1)) begin
      ptr_next = '0;
    end
  end

  // Scheduler FSM with registered operand, result and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ptr        <= '0;
      cnt        <= '0;
      add_a      <= '0;
      add_b      <= '0;
      grant_id   <= '0;
      resp_valid <= '0;
      resp_sum   <= '0;
      resp_cout  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_found) begin
            add_a    <= req_a[sel_idx*W +: W];
            add_b    <= req_b[sel_idx*W +: W];
            grant_id <= sel_idx;
            cnt      <= SETTLE_LOAD;
            busy     <= 1'b1;
            state    <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          // The load cycle counts as the first settle cycle
          if (cnt <= 4'd1) begin
            state <= S_CAPTURE;
          end
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
        end
        S_CAPTURE: begin
`ifdef CSELA_SCHED_SAT_EN
          if (add_cout) begin
            resp_sum <= '1;
          end else begin
            resp_sum <= add_sum;
          end
`else
          resp_sum <= add_sum;
`endif
          resp_cout  <= add_cout;
          resp_valid <= NREQ'(1) << grant_id;
          state      <= S_RESP;
        end
        S_RESP: begin
          // Only the granted requester's resp_ready completes the response
          if (resp_ready[grant_id]) begin
            resp_valid <= '0;
            ptr        <= ptr_next;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csela_add_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_csela_add_sched
// Summary  : Self-checking bench for csela_add_sched with an external
//            adder model and a transaction-level reference of the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csela_add_sched;

  localparam int W      = 64;
  localparam int NREQ   = 4;
  localparam int SETTLE = 2;
  localparam int GW     = 2;
  localparam int LAT    = SETTLE + 2;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*W-1:0]   req_a;
  logic [NREQ*W-1:0]   req_b;
  logic [NREQ-1:0]     resp_valid;
  logic [NREQ-1:0]     resp_ready;
  logic [W-1:0]        resp_sum;
  logic                resp_cout;
  logic [W-1:0]        add_a;
  logic [W-1:0]        add_b;
  logic [W-1:0]        add_sum;
  logic                add_cout;
  logic                busy;
  logic [GW-1:0]       grant_id;

  // External combinational adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  csela_add_sched #(.W(W), .NREQ(NREQ), .SETTLE_CYC(SETTLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .resp_cout  (resp_cout),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_sum    (add_sum),
    .add_cout   (add_cout),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference
  logic            m_busy;
  int              m_gid;
  int              m_ptr;
  int              m_age;
  logic [W-1:0]    m_a, m_b, m_sum;
  logic            m_cout;
  logic [NREQ-1:0] sticky;

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_gid = 0; m_ptr = 0; m_age = 0;
    m_a = '0; m_b = '0; m_sum = '0; m_cout = 1'b0;
  endtask

  // Compare all outputs for the current cycle, then advance the model
  // across the coming rising edge; ends on the next falling edge.
  task automatic tick();
    int              pick;
    logic [NREQ-1:0] exp_rv;
    logic [W:0]      full;
    #1;
    pick = m_busy ? -1 : rr_pick(req_valid, m_ptr);
    check("req_ready", 64'(req_ready), (pick < 0) ? 64'd0 : (64'd1 << pick));
    check("busy", 64'(busy), 64'(m_busy));
    check("grant_id", 64'(grant_id), 64'(m_gid));
    check("add_a", add_a, m_a);
    check("add_b", add_b, m_b);
    exp_rv = (m_busy && m_age >= LAT) ? (NREQ'(1) << m_gid) : '0;
    check("resp_valid", 64'(resp_valid), 64'(exp_rv));
    check("resp_sum", resp_sum, m_sum);
    check("resp_cout", 64'(resp_cout), 64'(m_cout));
    if (pick >= 0) begin
      m_busy = 1'b1;
      m_gid  = pick;
      m_a    = req_a[pick*W +: W];
      m_b    = req_b[pick*W +: W];
      m_age  = 0;
    end else if (m_busy && m_age >= LAT && resp_ready[m_gid]) begin
      m_busy = 1'b0;
      m_ptr  = (m_gid + 1) % NREQ;
    end
    if (m_busy) begin
      m_age++;
      if (m_age == LAT) begin
        full   = {1'b0, m_a} + {1'b0, m_b};
        m_sum  = full[W-1:0];
        m_cout = full[W];
`ifdef CSELA_SCHED_SAT_EN
        if (m_cout) m_sum = '1;
`endif
      end
    end
    @(negedge clk);
    if (pick >= 0 && !sticky[pick]) req_valid[pick] = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic post(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_valid[idx]    = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    check({tag, "_resp_sum"}, resp_sum, 64'd0);
    check({tag, "_resp_cout"}, 64'(resp_cout), 64'd0);
    check({tag, "_add_a"}, add_a, 64'd0);
    check({tag, "_add_b"}, add_b, 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_grant_id"}, 64'(grant_id), 64'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = '0;
    sticky     = '0;
    model_reset();
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    check_zero("reset");
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single request from requester 0
    resp_ready = '1;
    post(0, 64'd998, 64'd128);
    run(7);

    // Two back-to-back requests from requester 2
    post(2, 64'd9998, 64'd9028);
    run(6);
    post(2, 64'd9989998, 64'd769028);
    run(6);

    // Carry-out boundary
    post(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    run(6);

    // All requesters continuously requesting
    sticky = '1;
    for (int i = 0; i < NREQ; i++) post(i, 64'(i * 1000 + 7), 64'(i + 1));
    run(5 * 5 + 1);
    sticky    = '0;
    req_valid = '0;
    run(6);

    // Requester 1 response stalled for 6 cycles
    resp_ready = 4'b1101;
    post(1, 64'd123456789, 64'd987654321);
    run(LAT + 6);
    resp_ready = '1;
    run(3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req_valid = NREQ'($urandom);
      for (int r = 0; r < NREQ; r++) begin
        if ($urandom_range(0, 2) == 0) begin
          req_a[r*W +: W] = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
          req_b[r*W +: W] = {$urandom, $urandom};
        end
      end
      resp_ready = NREQ'($urandom);
      tick();
    end
    req_valid  = '0;
    resp_ready = '1;
    run(8);

    // Reset during SETTLE, with the pointer first moved away from 0
    post(1, 64'd5, 64'd6);
    run(6);
    sticky = 4'b1000;
    post(3, 64'd1000, 64'd2000);
    run(2);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    sticky = '0;
    post(1, 64'd40, 64'd2);
    run(12);
    run(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
